// File: rtl/nnrv_wb.sv
// nnrv writeback stage: retires ALU/link/load results into the register file,
// extracts sub-word load data, flags the pending load rd and reports load faults.
module nnrv_wb #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_kind,
    input  logic            i_rd_en,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_alu_res,
    input  logic [XLEN-1:0] i_pc,
    input  logic [2:0]      i_funct3,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_w_en,
    output logic [4:0]      o_w,
    output logic [XLEN-1:0] o_w_reg,
    output logic            o_pend_valid,
    output logic [4:0]      o_pend_rd,
    output logic            o_exc,
    output logic [XLEN-1:0] o_exc_pc,
    output logic [63:0]     o_instret
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_e;

    localparam logic [1:0] KIND_ALU  = 2'b00;
    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_LINK = 2'b10;
    localparam logic [1:0] KIND_RSVD = 2'b11;

    // Returns 1 when the funct3/byte-offset pair cannot be serviced as a load.
    function automatic logic load_illegal(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b100:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b101:  bad = a[0];
            3'b010:  bad = (a != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Selects the addressed byte/halfword of an aligned word and extends it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = 8'd0;
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = d;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_e          state_r;
    logic [4:0]      ld_rd_r;
    logic            ld_rd_en_r;
    logic [2:0]      ld_funct3_r;
    logic [1:0]      ld_addr_r;
    logic            retire_r;

    logic            accept_s;
    logic            exc_s;
    logic [XLEN-1:0] nonload_data_s;
    logic [XLEN-1:0] load_data_s;

    assign o_ready = (state_r == ST_IDLE);

    // Accept decode, fault detection and write-data selection for this cycle.
    always_comb begin
        accept_s       = i_valid && (state_r == ST_IDLE);
        nonload_data_s = {XLEN{1'b0}};
        exc_s          = 1'b0;
        case (i_kind)
            KIND_ALU:  nonload_data_s = i_alu_res;
            KIND_LINK: nonload_data_s = i_pc + XLEN'(32'd4);
            KIND_LOAD: exc_s = load_illegal(i_funct3, i_alu_res[1:0]);
            KIND_RSVD: exc_s = 1'b1;
            default:   exc_s = 1'b1;
        endcase
        load_data_s = load_extract(ld_funct3_r, ld_addr_r, i_mem_rdata);
    end

    // State machine with registered write port, pending-load flags, fault and retire count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            ld_rd_r      <= 5'd0;
            ld_rd_en_r   <= 1'b0;
            ld_funct3_r  <= 3'd0;
            ld_addr_r    <= 2'd0;
            retire_r     <= 1'b0;
            o_w_en       <= 1'b0;
            o_w          <= 5'd0;
            o_w_reg      <= {XLEN{1'b0}};
            o_pend_valid <= 1'b0;
            o_pend_rd    <= 5'd0;
            o_exc        <= 1'b0;
            o_exc_pc     <= {XLEN{1'b0}};
            o_instret    <= 64'd0;
        end else begin
            o_w_en    <= 1'b0;
            o_w       <= 5'd0;
            o_w_reg   <= {XLEN{1'b0}};
            o_exc     <= 1'b0;
            retire_r  <= 1'b0;
            // The count lags the write by one cycle because it follows retire_r.
            o_instret <= o_instret + {63'd0, retire_r};
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (exc_s) begin
                            o_exc    <= 1'b1;
                            o_exc_pc <= i_pc;
                        end else if (i_kind == KIND_LOAD) begin
                            state_r      <= ST_WAIT_MEM;
                            ld_rd_r      <= i_rd;
                            ld_rd_en_r   <= i_rd_en;
                            ld_funct3_r  <= i_funct3;
                            ld_addr_r    <= i_alu_res[1:0];
                            o_pend_valid <= 1'b1;
                            o_pend_rd    <= i_rd_en ? i_rd : 5'd0;
                        end else begin
                            retire_r <= 1'b1;
                            if (i_rd_en && (i_rd != 5'd0)) begin
                                o_w_en  <= 1'b1;
                                o_w     <= i_rd;
                                o_w_reg <= nonload_data_s;
                            end else begin
                                o_w_en  <= 1'b0;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_MEM: begin
                    if (i_mem_rvalid) begin
                        state_r      <= ST_IDLE;
                        o_pend_valid <= 1'b0;
                        o_pend_rd    <= 5'd0;
                        retire_r     <= 1'b1;
                        if (ld_rd_en_r && (ld_rd_r != 5'd0)) begin
                            o_w_en  <= 1'b1;
                            o_w     <= ld_rd_r;
                            o_w_reg <= load_data_s;
                        end else begin
                            o_w_en  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_WAIT_MEM;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    o_pend_valid <= 1'b0;
                    o_pend_rd    <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nnrv_wb.sv
// Bench for nnrv_wb: vector table driven through a timed scoreboard, plus
// hand sequences for pending-load, back-to-back and reset-in-wait behaviour.
module tb_nnrv_wb;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_kind;
    logic        i_rd_en;
    logic [4:0]  i_rd;
    logic [31:0] i_alu_res;
    logic [31:0] i_pc;
    logic [2:0]  i_funct3;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_w_en;
    logic [4:0]  o_w;
    logic [31:0] o_w_reg;
    logic        o_pend_valid;
    logic [4:0]  o_pend_rd;
    logic        o_exc;
    logic [31:0] o_exc_pc;
    logic [63:0] o_instret;

    nnrv_wb #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_kind(i_kind), .i_rd_en(i_rd_en), .i_rd(i_rd), .i_alu_res(i_alu_res),
        .i_pc(i_pc), .i_funct3(i_funct3), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata), .o_w_en(o_w_en), .o_w(o_w), .o_w_reg(o_w_reg),
        .o_pend_valid(o_pend_valid), .o_pend_rd(o_pend_rd), .o_exc(o_exc),
        .o_exc_pc(o_exc_pc), .o_instret(o_instret)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic        rd_en;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          wait_cyc;
        logic        exp_w_en;
        logic [31:0] exp_wreg;
        logic        exp_exc;
    } vec_t;

    typedef struct {
        int          at_cyc;
        logic        w_en;
        logic [4:0]  w;
        logic [31:0] w_reg;
        logic        exc;
        logic [31:0] exc_pc;
        logic        retire;
    } exp_t;

    localparam int NV = 22;
    vec_t  vecs [NV];
    exp_t  sb [$];
    exp_t  mon_e;
    logic  mon_hit;
    logic  mon_en = 1'b0;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    logic [63:0] exp_instret = 64'd0;
    logic [31:0] exp_exc_pc = 32'd0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic w_en, input logic [4:0] w, input logic [31:0] wr,
                        input logic exc, input logic [31:0] epc, input logic ret);
        exp_t e;
        e.at_cyc = cyc + 1;
        e.w_en   = w_en;
        e.w      = w;
        e.w_reg  = wr;
        e.exc    = exc;
        e.exc_pc = epc;
        e.retire = ret;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every cycle the write port must match the due entry or be idle.
    always @(negedge i_clk) begin
        if (i_rst || !mon_en) begin
            sb.delete();
            exp_instret = 64'd0;
            exp_exc_pc  = 32'd0;
        end else begin
            mon_e   = '{at_cyc: 0, w_en: 1'b0, w: 5'd0, w_reg: 32'd0, exc: 1'b0, exc_pc: 32'd0, retire: 1'b0};
            mon_hit = 1'b0;
            while (sb.size() > 0 && sb[0].at_cyc < cyc) begin
                void'(sb.pop_front());
                n_checks++;
                n_errors++;
                $display("FAIL sb_missed: expected entry never matched (cycle %0d)", cyc);
            end
            if (sb.size() > 0 && sb[0].at_cyc == cyc) begin
                mon_e   = sb.pop_front();
                mon_hit = 1'b1;
            end
            if (mon_hit && mon_e.exc) exp_exc_pc = mon_e.exc_pc;
            chk("w_en",    {63'd0, o_w_en},   {63'd0, mon_e.w_en});
            chk("w",       {59'd0, o_w},      {59'd0, mon_e.w});
            chk("w_reg",   {32'd0, o_w_reg},  {32'd0, mon_e.w_reg});
            chk("exc",     {63'd0, o_exc},    {63'd0, mon_e.exc});
            chk("exc_pc",  {32'd0, o_exc_pc}, {32'd0, exp_exc_pc});
            chk("instret", o_instret,         exp_instret);
            if (mon_hit && mon_e.retire) exp_instret = exp_instret + 64'd1;
        end
    end

    task automatic idle_inputs();
        i_valid = 1'b0; i_kind = 2'b00; i_rd_en = 1'b0; i_rd = 5'd0;
        i_alu_res = 32'd0; i_pc = 32'd0; i_funct3 = 3'd0;
        i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
    endtask

    // Drive one vector starting just after a rising edge; returns just after a rising edge.
    task automatic apply(input vec_t v);
        i_valid = 1'b1; i_kind = v.kind; i_rd_en = v.rd_en; i_rd = v.rd;
        i_alu_res = v.alu; i_pc = v.pc; i_funct3 = v.f3;
        if (v.kind == 2'b01 && !v.exp_exc) begin
            // Data offered in the accept cycle must be ignored.
            i_mem_rvalid = 1'b1; i_mem_rdata = ~v.rdata;
            @(posedge i_clk); #1;
            i_valid = 1'b0; i_mem_rvalid = 1'b0;
            for (int w = 1; w < v.wait_cyc; w++) begin
                @(posedge i_clk); #1;
            end
            i_mem_rvalid = 1'b1; i_mem_rdata = v.rdata;
            push(v.exp_w_en, v.exp_w_en ? v.rd : 5'd0, v.exp_wreg, 1'b0, v.pc, 1'b1);
            @(posedge i_clk); #1;
            i_mem_rvalid = 1'b0;
        end else begin
            push(v.exp_w_en, v.exp_w_en ? v.rd : 5'd0, v.exp_wreg, v.exp_exc, v.pc, !v.exp_exc);
            @(posedge i_clk); #1;
            i_valid = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = '{2'b00, 3'd0,   1'b1, 5'd5,  32'hDEADBEEF, 32'h0000_0000, 32'h0,         0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{2'b10, 3'd0,   1'b1, 5'd1,  32'h0,        32'hFFFF_FFFC, 32'h0,         0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[2]  = '{2'b00, 3'd0,   1'b1, 5'd0,  32'h1234,     32'h0000_0010, 32'h0,         0, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{2'b01, 3'b000, 1'b1, 5'd7,  32'h1003,     32'h0000_0040, 32'h80112233,  1, 1'b1, 32'hFFFFFF80, 1'b0};
        vecs[4]  = '{2'b01, 3'b100, 1'b1, 5'd8,  32'h1003,     32'h0000_0044, 32'h80112233,  2, 1'b1, 32'h00000080, 1'b0};
        vecs[5]  = '{2'b01, 3'b101, 1'b1, 5'd9,  32'h1002,     32'h0000_0048, 32'h80112233,  3, 1'b1, 32'h00008011, 1'b0};
        vecs[6]  = '{2'b01, 3'b001, 1'b1, 5'd10, 32'h1002,     32'h0000_004C, 32'h80112233,  1, 1'b1, 32'hFFFF8011, 1'b0};
        vecs[7]  = '{2'b01, 3'b000, 1'b1, 5'd11, 32'h1001,     32'h0000_0050, 32'h80112233,  2, 1'b1, 32'h00000022, 1'b0};
        vecs[8]  = '{2'b01, 3'b010, 1'b1, 5'd31, 32'h2000,     32'h0000_0054, 32'hCAFEF00D,  1, 1'b1, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{2'b01, 3'b001, 1'b1, 5'd12, 32'h2000,     32'h0000_0058, 32'h1234F00D,  1, 1'b1, 32'hFFFFF00D, 1'b0};
        vecs[10] = '{2'b01, 3'b010, 1'b1, 5'd13, 32'h2002,     32'h0000_0100, 32'h0,         0, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{2'b01, 3'b111, 1'b1, 5'd14, 32'h2000,     32'h0000_0204, 32'h0,         0, 1'b0, 32'h0,        1'b1};
        vecs[12] = '{2'b01, 3'b001, 1'b1, 5'd15, 32'h2001,     32'h0000_0300, 32'h0,         0, 1'b0, 32'h0,        1'b1};
        vecs[13] = '{2'b11, 3'b000, 1'b1, 5'd16, 32'h5,        32'h0000_0404, 32'h0,         0, 1'b0, 32'h0,        1'b1};
        vecs[14] = '{2'b01, 3'b010, 1'b0, 5'd9,  32'h3000,     32'h0000_0060, 32'h55AA55AA,  2, 1'b0, 32'h0,        1'b0};
        vecs[15] = '{2'b00, 3'd0,   1'b0, 5'd3,  32'hFFFF,     32'h0000_0064, 32'h0,         0, 1'b0, 32'h0,        1'b0};
        vecs[16] = '{2'b01, 3'b100, 1'b1, 5'd17, 32'h3000,     32'h0000_0068, 32'h000000FF,  1, 1'b1, 32'h000000FF, 1'b0};
        vecs[17] = '{2'b01, 3'b000, 1'b1, 5'd18, 32'h3002,     32'h0000_006C, 32'h00FF0000,  1, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[18] = '{2'b01, 3'b110, 1'b1, 5'd20, 32'h3000,     32'h0000_0500, 32'h0,         0, 1'b0, 32'h0,        1'b1};
        vecs[19] = '{2'b01, 3'b101, 1'b1, 5'd19, 32'h3001,     32'h0000_0600, 32'h0,         0, 1'b0, 32'h0,        1'b1};
        vecs[20] = '{2'b01, 3'b011, 1'b1, 5'd21, 32'h3000,     32'h0000_0700, 32'h0,         0, 1'b0, 32'h0,        1'b1};
        vecs[21] = '{2'b10, 3'd0,   1'b1, 5'd2,  32'h0,        32'h0000_1000, 32'h0,         0, 1'b1, 32'h00001004, 1'b0};

        idle_inputs();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready",   {63'd0, o_ready},      64'd1);
        chk("rst_w_en",    {63'd0, o_w_en},       64'd0);
        chk("rst_w_reg",   {32'd0, o_w_reg},      64'd0);
        chk("rst_pend",    {63'd0, o_pend_valid}, 64'd0);
        chk("rst_pend_rd", {59'd0, o_pend_rd},    64'd0);
        chk("rst_exc",     {63'd0, o_exc},        64'd0);
        chk("rst_exc_pc",  {32'd0, o_exc_pc},     64'd0);
        chk("rst_instret", o_instret,             64'd0);
        i_rst  = 1'b0;
        mon_en = 1'b1;
        @(posedge i_clk); #1;

        for (int k = 0; k < NV; k++) apply(vecs[k]);

        // LB rd=12 with data three cycles after accept: pending flags held throughout.
        i_valid = 1'b1; i_kind = 2'b01; i_rd_en = 1'b1; i_rd = 5'd12;
        i_alu_res = 32'h4003; i_pc = 32'h0000_0800; i_funct3 = 3'b000;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            if (w == 2) begin
                i_mem_rvalid = 1'b1; i_mem_rdata = 32'h80112233;
                push(1'b1, 5'd12, 32'hFFFFFF80, 1'b0, 32'h0, 1'b1);
            end
            @(negedge i_clk);
            chk("wait_pend",    {63'd0, o_pend_valid}, 64'd1);
            chk("wait_pend_rd", {59'd0, o_pend_rd},    64'd12);
            chk("wait_ready",   {63'd0, o_ready},      64'd0);
            @(posedge i_clk); #1;
        end
        i_mem_rvalid = 1'b0;
        @(negedge i_clk);
        chk("done_ready",   {63'd0, o_ready},      64'd1);
        chk("done_pend",    {63'd0, o_pend_valid}, 64'd0);
        chk("done_pend_rd", {59'd0, o_pend_rd},    64'd0);
        @(posedge i_clk); #1;

        // Fresh count, then ten back-to-back ALU accepts.
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1; i_kind = 2'b00; i_rd_en = 1'b1; i_rd = 5'(k + 1);
            i_alu_res = 32'h1111_1111 * 32'(k); i_pc = 32'(k * 4);
            push(1'b1, 5'(k + 1), 32'h1111_1111 * 32'(k), 1'b0, 32'h0, 1'b1);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("b2b_instret", o_instret, 64'd10);
        @(posedge i_clk); #1;

        // Load with data only in its accept cycle must keep waiting; then reset mid-wait.
        i_valid = 1'b1; i_kind = 2'b01; i_rd_en = 1'b1; i_rd = 5'd4;
        i_alu_res = 32'h5000; i_funct3 = 3'b010; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_rvalid = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            chk("hold_ready",   {63'd0, o_ready},      64'd0);
            chk("hold_pend",    {63'd0, o_pend_valid}, 64'd1);
            chk("hold_pend_rd", {59'd0, o_pend_rd},    64'd4);
            @(posedge i_clk); #1;
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rstw_ready", {63'd0, o_ready},      64'd1);
        chk("rstw_pend",  {63'd0, o_pend_valid}, 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hA5A5_A5A5;
        repeat (3) begin
            @(negedge i_clk);
            chk("post_ready",   {63'd0, o_ready},      64'd1);
            chk("post_pend",    {63'd0, o_pend_valid}, 64'd0);
            chk("post_w_en",    {63'd0, o_w_en},       64'd0);
            chk("post_instret", o_instret,             64'd0);
            @(posedge i_clk); #1;
        end
        i_mem_rvalid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
